// File: rtl/factor_witness_search.sv
// Sequential factor-pair search: sweeps divisor candidates b = 2 .. 2^B_W-1 and
// divides the target with a bit-serial restoring divider, reporting the first exact pair.
module factor_witness_search #(
  parameter int A_W = 8,
  parameter int B_W = 5,
  parameter int N_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [N_W-1:0] target_i,
  output logic           busy_o,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic           found_o,
  output logic [A_W-1:0] a_o,
  output logic [B_W-1:0] b_o
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    CHECK,
    DONE
  } state_t;

  state_t state, state_next;

  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   rem_q;
  logic [N_W-1:0]   quo_q;
  logic [B_W-1:0]   b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             found_q;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_res_q;

  logic [N_W-1:0] rem_shift;
  logic [N_W-1:0] b_ext;
  logic           sub_ok;
  logic [N_W-1:0] rem_step;
  logic [N_W-1:0] quo_step;
  logic           quo_fits;
  logic           check_pass;
  logic           last_cand;

  // One restoring-division step; rem < b always holds, so rem_shift never overflows N_W bits.
  always_comb begin
    rem_shift = {rem_q[N_W-2:0], quo_q[N_W-1]};
    b_ext     = {{(N_W-B_W){1'b0}}, b_q};
    sub_ok    = (rem_shift >= b_ext);
    rem_step  = sub_ok ? (rem_shift - b_ext) : rem_shift;
    quo_step  = {quo_q[N_W-2:0], sub_ok};
  end

  // Overflowing quotients are rejected outright rather than truncated into a_o.
  always_comb begin
    quo_fits   = (quo_q[N_W-1:A_W] == '0);
    check_pass = (rem_q == '0) && quo_fits && (quo_q >= N_W'(2));
    last_cand  = &b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (cnt_q == '0) state_next = CHECK;
      CHECK:   state_next = (check_pass || last_cand) ? DONE : LOAD;
      DONE:    if (res_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      a_q     <= '0;
      b_res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            n_q     <= target_i;
            b_q     <= B_W'(2);
            found_q <= 1'b0;
            a_q     <= '0;
            b_res_q <= '0;
          end
        end
        LOAD: begin
          rem_q <= '0;
          quo_q <= n_q;
          cnt_q <= CNT_W'(N_W - 1);
        end
        DIV: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q - 1'b1;
        end
        CHECK: begin
          if (check_pass) begin
            found_q <= 1'b1;
            a_q     <= quo_q[A_W-1:0];
            b_res_q <= b_q;
          end else if (last_cand) begin
            found_q <= 1'b0;
            a_q     <= '0;
            b_res_q <= '0;
          end else begin
            b_q <= b_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state == LOAD) || (state == DIV) || (state == CHECK);
    res_valid_o = (state == DONE);
    found_o     = found_q;
    a_o         = a_q;
    b_o         = b_res_q;
  end

endmodule

// File: tb/tb_factor_witness_search.sv
// Directed and reference-model checks for factor_witness_search: results, latency,
// handshake hold behaviour and asynchronous reset during a search.
module tb_factor_witness_search;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [12:0] target_i = '0;
  logic        busy_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic        found_o;
  logic [7:0]  a_o;
  logic [4:0]  b_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  factor_witness_search #(.A_W(8), .B_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .target_i(target_i),
    .busy_o(busy_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .found_o(found_o),
    .a_o(a_o),
    .b_o(b_o)
  );

  typedef struct {
    logic [12:0] target;
    logic        found;
    logic [7:0]  a;
    logic [4:0]  b;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Smallest b in 2..31 with an exact quotient in 2..255.
  task automatic ref_model(input int n, output vec_t v);
    v.target = 13'(n);
    v.found = 1'b0; v.a = '0; v.b = '0; v.lat = 451;
    for (int b = 2; b < 32; b++) begin
      if ((n % b) == 0 && (n / b) >= 2 && (n / b) < 256) begin
        v.found = 1'b1; v.a = 8'(n / b); v.b = 5'(b); v.lat = 15 * (b - 1) + 1;
        break;
      end
    end
  endtask

  // Start at edge 0; returns the cycle index in which res_valid_o is first seen.
  task automatic do_search(input logic [12:0] t, output int lat, output int busy_bad);
    int cyc;
    @(negedge clk);
    target_i = t;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    busy_bad = 0;
    while (!res_valid_o && cyc < 600) begin
      if (busy_o !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy_o !== 1'b0) busy_bad++;
    lat = cyc;
  endtask

  initial begin
    int lat, busy_bad, stable_bad;
    logic [7:0] a_hold;
    logic [4:0] b_hold;
    vec_t rv;

    vecs[0]  = '{13'd143,  1'b1, 8'd13,  5'd11, 151};
    vecs[1]  = '{13'd311,  1'b0, 8'd0,   5'd0,  451};
    vecs[2]  = '{13'd4,    1'b1, 8'd2,   5'd2,  16};
    vecs[3]  = '{13'd1000, 1'b1, 8'd250, 5'd4,  46};
    vecs[4]  = '{13'd0,    1'b0, 8'd0,   5'd0,  451};
    vecs[5]  = '{13'd1,    1'b0, 8'd0,   5'd0,  451};
    vecs[6]  = '{13'd2,    1'b0, 8'd0,   5'd0,  451};
    vecs[7]  = '{13'd6,    1'b1, 8'd3,   5'd2,  16};
    vecs[8]  = '{13'd9,    1'b1, 8'd3,   5'd3,  31};
    vecs[9]  = '{13'd961,  1'b1, 8'd31,  5'd31, 451};
    vecs[10] = '{13'd7905, 1'b1, 8'd255, 5'd31, 451};
    vecs[11] = '{13'd7936, 1'b0, 8'd0,   5'd0,  451};
    vecs[12] = '{13'd8191, 1'b0, 8'd0,   5'd0,  451};
    vecs[13] = '{13'd510,  1'b1, 8'd255, 5'd2,  16};
    vecs[14] = '{13'd512,  1'b1, 8'd128, 5'd4,  46};
    vecs[15] = '{13'd4096, 1'b0, 8'd0,   5'd0,  451};

    #12;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_valid", int'(res_valid_o), 0);
    chk("reset_found", int'(found_o), 0);
    chk("reset_a", int'(a_o), 0);
    chk("reset_b", int'(b_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      res_ready_i = 1'b1;
      do_search(vecs[i].target, lat, busy_bad);
      $display("vec %0d: N=%0d found=%0d a=%0d b=%0d lat=%0d", i, vecs[i].target,
               found_o, a_o, b_o, lat);
      chk("latency", lat, vecs[i].lat);
      chk("found", int'(found_o), int'(vecs[i].found));
      chk("a", int'(a_o), int'(vecs[i].a));
      chk("b", int'(b_o), int'(vecs[i].b));
      chk("busy_window", busy_bad, 0);
      @(posedge clk); #1;
      chk("valid_drop", int'(res_valid_o), 0);
    end

    // Result held with ready low; start pulses with a new target must be ignored.
    res_ready_i = 1'b0;
    do_search(13'd143, lat, busy_bad);
    chk("hold_latency", lat, 151);
    a_hold = a_o;
    b_hold = b_o;
    stable_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start_i = c[0];
      target_i = 13'd4;
      @(posedge clk); #1;
      if (res_valid_o !== 1'b1 || busy_o !== 1'b0 || found_o !== 1'b1 ||
          a_o !== a_hold || b_o !== b_hold) stable_bad++;
    end
    $display("hold: a=%0d b=%0d stable_bad=%0d", a_o, b_o, stable_bad);
    chk("hold_stable", stable_bad, 0);
    chk("hold_a", int'(a_hold), 13);
    chk("hold_b", int'(b_hold), 11);
    @(negedge clk);
    start_i = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("handshake_valid", int'(res_valid_o), 0);
    chk("handshake_busy", int'(busy_o), 0);
    @(posedge clk); #1;
    chk("idle_busy", int'(busy_o), 0);
    chk("kept_a", int'(a_o), 13);
    chk("kept_found", int'(found_o), 1);

    // Asynchronous reset in cycle 40 of a 311 search, then a fresh 143 search.
    @(negedge clk);
    target_i = 13'd311;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0d valid=%0d found=%0d a=%0d b=%0d",
             busy_o, res_valid_o, found_o, a_o, b_o);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_valid", int'(res_valid_o), 0);
    chk("arst_found", int'(found_o), 0);
    chk("arst_a", int'(a_o), 0);
    chk("arst_b", int'(b_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_search(13'd143, lat, busy_bad);
    $display("after reset: N=143 found=%0d a=%0d b=%0d lat=%0d", found_o, a_o, b_o, lat);
    chk("post_rst_latency", lat, 151);
    chk("post_rst_a", int'(a_o), 13);
    chk("post_rst_b", int'(b_o), 11);
    chk("post_rst_busy", busy_bad, 0);
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      ref_model(int'($urandom_range(0, 8191)), rv);
      do_search(rv.target, lat, busy_bad);
      $display("rand %0d: N=%0d found=%0d a=%0d b=%0d lat=%0d", r, rv.target,
               found_o, a_o, b_o, lat);
      chk("rand_latency", lat, rv.lat);
      chk("rand_found", int'(found_o), int'(rv.found));
      chk("rand_a", int'(a_o), int'(rv.a));
      chk("rand_b", int'(b_o), int'(rv.b));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // busy_o and res_valid_o must never be high together.
  int overlap_seen = 0;
  always @(negedge clk) begin
    if (busy_o === 1'b1 && res_valid_o === 1'b1 && overlap_seen == 0) begin
      overlap_seen = 1;
      chk("busy_valid_overlap", 1, 0);
    end
  end

endmodule

// File: doc/factor_witness_search.md
Name: factor_witness_search

Overview:
- Sequential factorization engine; the generating counterpart of the multiplier_factorize SAT checkers.
- Those checkers assert sat when the operand pair (a, b) multiplies to a fixed target. This block takes a runtime target N and searches for a satisfying pair.
- Sweeps candidate b upward and divides N by b with a bit-serial restoring divider. Returns the first exact factor pair whose quotient fits in A_W bits.
- Used as a hardware oracle to generate and cross-check expected sat/unsat results for the benchmark circuits.

Parameters:
- A_W, 8, width of factor a (the quotient).
- B_W, 5, width of factor b (the divisor candidate).
- N_W, A_W+B_W, width of target N and of the internal dividend/remainder datapath.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- target_i  input  N_W  target N; captured on the start cycle.
- busy_o  output  1  high in LOAD, DIV and CHECK.
- res_valid_o  output  1  result available; held until accepted.
- res_ready_i  input  1  consumer accepts the result.
- found_o  output  1  1 = witness found (sat), 0 = search exhausted (unsat).
- a_o  output  A_W  quotient factor; 0 when found_o = 0.
- b_o  output  B_W  divisor factor; 0 when found_o = 0.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, internal registers cleared. Reset is asynchronous, so it takes effect immediately, including mid-search; the search is abandoned and no result is produced.
- States: IDLE, LOAD, DIV, CHECK, DONE.
- IDLE: on start_i = 1, capture N into n_q, set b_q = 2, go to LOAD. start_i in any other state is ignored.
- LOAD (1 cycle): rem = 0, quo = n_q, bit counter = N_W-1. Next state DIV.
- DIV (N_W cycles): one restoring step per cycle, MSB first.
  - Shift: rem' = {rem[N_W-2:0], quo msb}, then shift quo left.
  - If rem' >= zero-extended b_q: rem = rem' - b_q and the quotient lsb = 1; else the quotient lsb = 0.
  - rem and quo are N_W bits wide. Go to CHECK after the step with counter = 0.
- CHECK (1 cycle): success when rem == 0, quo < 2^A_W and quo >= 2.
  - On success: a_o = quo[A_W-1:0], b_o = b_q, found_o = 1, go to DONE.
  - Else if b_q == 2^B_W-1 (last candidate): found_o = 0, a_o = 0, b_o = 0, go to DONE.
  - Else: b_q++, go to LOAD.
- Per-candidate cost: exactly N_W+2 cycles.
- Result timing: first rising edge with start_i high = edge 0. Candidate k (b = k+1) reaches CHECK in cycle 15k for the defaults. res_valid_o rises in the cycle after the deciding CHECK.
- DONE: res_valid_o = 1 with found_o/a_o/b_o stable. When res_valid_o and res_ready_i are both high on an edge, clear res_valid_o and return to IDLE. found_o/a_o/b_o keep their values until the next start. res_ready_i is don't-care when res_valid_o = 0.
- busy_o = 1 exactly in LOAD/DIV/CHECK. res_valid_o and busy_o are never high together.
- Candidate range and search order:
  - b takes every value 2..2^B_W-1, in increasing order.
  - b_q wrap-around is impossible by construction; the terminal check precedes the increment.
  - The first passing b in this order is reported, i.e. the smallest b with a valid a.
- Degenerate targets: no special-casing. N = 0, 1, or a prime with no in-range factor runs the full sweep and reports found_o = 0.
- Quotient overflow (quo >= 2^A_W): that candidate is rejected, not truncated.
- No back-pressure during search. A new start is accepted only after the result has been consumed.

Test Plan:
- Target 143, start at edge 0, res_ready_i = 1 → res_valid_o rises at cycle 151 with found_o = 1, a_o = 13, b_o = 11. busy_o is high in cycles 1..150. res_valid_o drops one cycle later.
- Target 311 (prime) → res_valid_o at cycle 451 (30 candidates × 15), found_o = 0, a_o = 0, b_o = 0.
- Target 4 → found_o = 1, a_o = 2, b_o = 2 at cycle 16. Target 1000 (= 2 × 500, 500 overflows) → b = 4 is rejected for 250 < 256? No: 1000/4 = 250 fits, so expect a_o = 250, b_o = 4 at cycle 46.
- Hold result with res_ready_i = 0 for 20 cycles → outputs stable, and start_i pulses are ignored. Assert res_ready_i → one-cycle handshake, back to IDLE, busy_o stays 0.
- Assert rst_n low at cycle 40 of the target-311 search → all outputs 0 immediately. A new start with target 143 afterwards yields a_o = 13, b_o = 11 at cycle 151 after that start.
- Random 13-bit targets vs. a reference model: the smallest b in 2..31 with N mod b == 0 and 2 <= N/b < 256 must match found_o/a_o/b_o, and latency must equal 15·(b-1)+1 for found results, or 451 cycles for unsat results.
